// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the time-shared FIR: FSM states, accumulator sizing,
// and the round-half-up / saturate step applied to the final accumulator.
package fir_seq_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  typedef struct packed {
    logic              sat;
    logic signed [31:0] y;
  } sat_res_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  function automatic sat_res_t sat_round(input longint acc, input int shift, input int data_w);
    longint   r;
    longint   hi;
    longint   lo;
    sat_res_t res;
    r       = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
    hi      = (longint'(1) <<< (data_w - 1)) - 1;
    lo      = -hi - 1;
    res.sat = (r > hi) || (r < lo);
    res.y   = (r > hi) ? 32'(hi) : (r < lo) ? 32'(lo) : 32'(r);
    return res;
  endfunction

endpackage

// File: rtl/fir_seq_if.sv
// Sample, coefficient-write and result signals between the FIR and its host.
interface fir_seq_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 8
);
  localparam int AW = $clog2(NTAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x;
  logic                     bypass;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] y;
  logic                     sat;

  modport slave (
    input  in_valid, x, bypass, coef_we, coef_addr, coef_data,
    output in_ready, coef_ready, out_valid, y, sat
  );

  modport master (
    output in_valid, x, bypass, coef_we, coef_addr, coef_data,
    input  in_ready, coef_ready, out_valid, y, sat
  );
endinterface

// File: rtl/fir_seq_mac.sv
// Signed multiply-accumulate with synchronous clear and enable; one product per cycle.
// Latency: product lands in acc one cycle after en; no backpressure.
module fir_seq_mac #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [A_W+B_W-1:0] prod;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/fir_seq.sv
// Programmable direct-form FIR sharing one MAC across taps; out_valid NTAPS+1 cycles after accept
// (bypass: 1). in_ready/coef_ready only in IDLE; busy-time coefficient writes are dropped.
module fir_seq
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 8,
  parameter int SHIFT  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  fir_seq_if.slave   bus
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int IDX_W = $clog2(NTAPS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);

  fir_state_t               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     byp_q, byp_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     sat_q, sat_d;
  logic signed [DATA_W-1:0] taps_q [NTAPS];
  logic signed [DATA_W-1:0] taps_d [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];

  logic                     mac_clr;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc;
  sat_res_t                 res;
  logic signed [DATA_W-1:0] y_new;
  logic                     sat_new;
  logic                     unused_hi;

  fir_seq_mac #(.A_W(COEF_W), .B_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (coef_q[idx_q]),
    .b     (taps_q[idx_q]),
    .acc   (acc)
  );

  // In bypass, tap[0] already holds the latched sample.
  assign res       = sat_round(longint'(acc), SHIFT, DATA_W);
  assign unused_hi = ^res.y[31:DATA_W];
  assign y_new     = byp_q ? taps_q[0] : res.y[DATA_W-1:0];
  assign sat_new   = byp_q ? 1'b0 : res.sat;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byp_d   = byp_q;
    y_d     = y_q;
    sat_d   = sat_q;
    taps_d  = taps_q;
    coef_d  = coef_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    if (bus.coef_we && state_q == IDLE) begin
      coef_d[bus.coef_addr] = bus.coef_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          taps_d[0] = bus.x;
          for (int i = 1; i < NTAPS; i++) taps_d[i] = taps_q[i-1];
          mac_clr = 1'b1;
          idx_d   = '0;
          byp_d   = bus.bypass;
          state_d = bus.bypass ? OUT : MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST) state_d = OUT;
      end
      OUT: begin
        y_d     = y_new;
        sat_d   = sat_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      byp_q   <= 1'b0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        taps_q[i] <= '0;
        coef_q[i] <= (i == 0) ? COEF_W'(1 << SHIFT) : '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byp_q   <= byp_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      taps_q  <= taps_d;
      coef_q  <= coef_d;
    end
  end

  // y/sat show the new result during the out_valid cycle, then hold.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.coef_ready = (state_q == IDLE);
  assign bus.out_valid  = (state_q == OUT);
  assign bus.y          = (state_q == OUT) ? y_new : y_q;
  assign bus.sat        = (state_q == OUT) ? sat_new : sat_q;
endmodule

// File: tb/tb_fir_seq.sv
// Bench for fir_seq: vector table, directed corner sequences and random samples vs a sum-of-products model.
module tb_fir_seq;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NT = 8;
  localparam int SH = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_seq_if #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT)) bus ();
  fir_seq #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT), .SHIFT(SH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int hist [NT];
  int cf   [NT];

  typedef struct {
    int x;
    bit byp;
    int ey;
    int es;
  } vec_t;
  vec_t tbl [5];

  function automatic void check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      hist[i] = 0;
      cf[i]   = 0;
    end
    cf[0] = 1 << SH;
  endfunction

  function automatic void model_push(input int xv);
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = xv;
  endfunction

  // Exact sum of products, floor((s + half) / 2^SH), then clip to the sample range.
  function automatic void model_out(input int xv, input bit b, output int ey, output int es);
    longint s, num, q, den;
    if (b) begin
      ey = xv;
      es = 0;
      return;
    end
    s = 0;
    for (int i = 0; i < NT; i++) s += longint'(cf[i]) * longint'(hist[i]);
    den = longint'(1) << SH;
    num = s + den / 2;
    q   = num / den;
    if (num < 0 && (num % den) != 0) q = q - 1;
    es = 0;
    if (q > 127)       begin q = 127;  es = 1; end
    else if (q < -128) begin q = -128; es = 1; end
    ey = int'(q);
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.bypass    = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle(input string nm);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wcoef(input int a, input int d);
    wait_idle("wcoef");
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = 8'(d);
    @(negedge clk);
    bus.coef_we = 1'b0;
    cf[a] = d;
  endtask

  // One sample end-to-end: latency, y and sat checked against the model.
  task automatic sample(input string nm, input int xv, input bit b, input bit busy_wr,
                        output int yv, output int sv);
    int lat, ey, es;
    wait_idle(nm);
    bus.in_valid = 1'b1;
    bus.x        = 8'(xv);
    bus.bypass   = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    model_push(xv);
    model_out(xv, b, ey, es);
    while (!bus.out_valid && lat < 40) begin
      if (busy_wr) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'($urandom_range(0, NT - 1));
        bus.coef_data = 8'($urandom);
      end
      @(negedge clk);
      bus.coef_we = 1'b0;
      lat++;
    end
    yv = bus.y;
    sv = int'(bus.sat);
    check({nm, "_lat"}, lat, b ? 1 : NT + 1);
    check({nm, "_y"}, yv, ey);
    check({nm, "_sat"}, sv, es);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int yv, sv, ovc;
    int acc_at [$];
    int lows;

    tbl[0] = '{x: 10,  byp: 0, ey: 10,  es: 0};
    tbl[1] = '{x: -37, byp: 0, ey: -37, es: 0};
    tbl[2] = '{x: 1,   byp: 0, ey: 1,   es: 0};
    tbl[3] = '{x: -1,  byp: 0, ey: 0,   es: 0};
    tbl[4] = '{x: 5,   byp: 1, ey: 5,   es: 0};

    do_reset();
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_coef_ready", int'(bus.coef_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_sat", int'(bus.sat), 0);

    // Identity coefficients after reset, then half-LSB coefficient for rounding.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wcoef(0, 32);
      sample($sformatf("tbl%0d", i), tbl[i].x, tbl[i].byp, 1'b0, yv, sv);
      check($sformatf("tbl%0d_vec_y", i), yv, tbl[i].ey);
      check($sformatf("tbl%0d_vec_sat", i), sv, tbl[i].es);
    end

    // Impulse response through flat coefficients.
    for (int i = 0; i < NT; i++) wcoef(i, 8);
    for (int i = 0; i < NT; i++) sample("flush", 0, 1'b1, 1'b0, yv, sv);
    for (int i = 0; i < 16; i++) begin
      sample($sformatf("imp%0d", i), (i == 0) ? 64 : 0, 1'b0, 1'b0, yv, sv);
      check($sformatf("imp%0d_const", i), yv, (i < NT) ? 8 : 0);
    end

    // Saturation both ways, then bypass clears sat.
    for (int i = 0; i < NT; i++) wcoef(i, 63);
    for (int i = 0; i < NT; i++) sample("satp", 127, 1'b0, 1'b0, yv, sv);
    check("satp_const_y", yv, 127);
    check("satp_const_sat", sv, 1);
    for (int i = 0; i < NT; i++) sample("satn", -128, 1'b0, 1'b0, yv, sv);
    check("satn_const_y", yv, -128);
    check("satn_const_sat", sv, 1);
    sample("satbyp", 5, 1'b1, 1'b0, yv, sv);
    check("satbyp_const_y", yv, 5);
    check("satbyp_const_sat", sv, 0);

    // in_valid held high: one accept per NT+2 cycles.
    wait_idle("hold");
    bus.in_valid = 1'b1;
    bus.x        = '0;
    bus.bypass   = 1'b0;
    lows = 0;
    for (int c = 0; c < 35; c++) begin
      if (bus.in_ready) begin
        acc_at.push_back(c);
        model_push(0);
      end else begin
        lows++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("hold_accepts", acc_at.size(), 4);
    for (int i = 1; i < acc_at.size(); i++)
      check($sformatf("hold_interval%0d", i), acc_at[i] - acc_at[i-1], NT + 2);
    check("hold_ready_low", lows, 31);

    // Coefficient writes while busy must be ignored.
    sample("busywr_a", 77, 1'b0, 1'b1, yv, sv);
    sample("busywr_b", -90, 1'b0, 1'b1, yv, sv);

    // Reset during MAC cycle 3 aborts and restores identity coefficients.
    wait_idle("midrst");
    bus.in_valid = 1'b1;
    bus.x        = 8'(50);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ovc = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) rst_n = 1'b1;
      if (bus.out_valid) ovc++;
      @(negedge clk);
    end
    model_reset();
    check("midrst_no_out_valid", ovc, 0);
    check("midrst_y", int'(bus.y), 0);
    check("midrst_sat", int'(bus.sat), 0);
    sample("midrst_after", 20, 1'b0, 1'b0, yv, sv);
    check("midrst_after_const", yv, 20);

    // Random coefficients, samples, bypass and busy-time writes.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        wcoef($urandom_range(0, NT - 1), int'($urandom_range(0, 255)) - 128);
      sample($sformatf("rnd%0d", i), int'($urandom_range(0, 255)) - 128,
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, yv, sv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
